// File: rtl/rvv_defs.sv
// Shared definitions for the RVV write-back scheduler: requester IDs and
// register-index width.
package rvv_defs;

    localparam int VREG_ADDR_W   = 5;
    localparam int NUM_HAZ_PORTS = 3;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_MUL = 2'd1,
        REQ_LSU = 2'd2
    } req_id_e;

endpackage

// File: rtl/rvv_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, rotating priority pointer that moves
// to the requester after the winner and holds when nothing is granted.
module rvv_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    // Scan from the pointer upward (wrapping); first active request wins.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
                ptr_d        = PW'((idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rvv_vrf_wb_scheduler.sv
// Vector register-file write-back scheduler with optional pending-write
// scoreboard (enabled by defining RVV_SCOREBOARD_EN).
module rvv_vrf_wb_scheduler
    import rvv_defs::*;
#(
    parameter int VLEN     = 512,
    parameter int NUM_REGS = 32,
    parameter int NUM_REQ  = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*VREG_ADDR_W-1:0]      req_addr,
    input  logic [NUM_REQ*VLEN-1:0]             req_data,
    output logic                                rd_we,
    output logic [VREG_ADDR_W-1:0]              rd_addr,
    output logic [VLEN-1:0]                     rd_data,
    input  logic                                iss_valid,
    input  logic [VREG_ADDR_W-1:0]              iss_vd,
    output logic                                iss_ready,
    input  logic [NUM_HAZ_PORTS*VREG_ADDR_W-1:0] chk_addr,
    output logic [NUM_HAZ_PORTS-1:0]            chk_busy,
    output logic [NUM_REGS-1:0]                 busy_vec,
    output logic                                wb_err
);

    logic [NUM_REQ-1:0]     grant;
    logic                   rd_we_q, rd_we_d;
    logic [VREG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [VLEN-1:0]        rd_data_q, rd_data_d;

    rvv_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_valid),
        .grant_o (grant)
    );

    assign req_ready = grant;

    always_comb begin
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && grant[i]) begin
                rd_we_d   = 1'b1;
                rd_addr_d = req_addr[i*VREG_ADDR_W +: VREG_ADDR_W];
                rd_data_d = req_data[i*VLEN +: VLEN];
            end
        end
    end

    // Reset drops a write that was captured but not yet presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_we   = rd_we_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

`ifdef RVV_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wb_err_q, wb_err_d;

    // A commit to the same register on this edge frees the slot for reissue.
    assign iss_ready = !busy_q[iss_vd] || (rd_we_q && (rd_addr_q == iss_vd));

    // Set is applied after clear so a same-edge reissue keeps the bit set.
    always_comb begin
        busy_d   = busy_q;
        wb_err_d = wb_err_q;
        if (rd_we_q) begin
            busy_d[rd_addr_q] = 1'b0;
            if (!busy_q[rd_addr_q]) begin
                wb_err_d = 1'b1;
            end
        end
        if (iss_valid && iss_ready) begin
            busy_d[iss_vd] = 1'b1;
        end
    end

    always_comb begin
        chk_busy = '0;
        for (int k = 0; k < NUM_HAZ_PORTS; k++) begin
            chk_busy[k] = busy_q[chk_addr[k*VREG_ADDR_W +: VREG_ADDR_W]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign busy_vec = busy_q;
    assign wb_err   = wb_err_q;
`else
    logic unused_sb_inputs;

    assign unused_sb_inputs = ^{iss_valid, iss_vd, chk_addr};
    assign iss_ready        = 1'b1;
    assign chk_busy         = '0;
    assign busy_vec         = '0;
    assign wb_err           = 1'b0;
`endif

endmodule

// File: tb/tb_rvv_vrf_wb_scheduler.sv
// Self-checking bench for rvv_vrf_wb_scheduler: arbitration vector table,
// write-back scoreboard, hazard/reservation and reset sequences.
module tb_rvv_vrf_wb_scheduler;
  import rvv_defs::*;

  localparam int VLEN     = 512;
  localparam int NUM_REGS = 32;
  localparam int NUM_REQ  = 3;
  localparam int AW       = 5;
`ifdef RVV_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*AW-1:0]  req_addr;
  logic [NUM_REQ*VLEN-1:0] req_data;
  logic                   rd_we;
  logic [AW-1:0]          rd_addr;
  logic [VLEN-1:0]        rd_data;
  logic                   iss_valid;
  logic [AW-1:0]          iss_vd;
  logic                   iss_ready;
  logic [3*AW-1:0]        chk_addr;
  logic [2:0]             chk_busy;
  logic [NUM_REGS-1:0]    busy_vec;
  logic                   wb_err;

  rvv_vrf_wb_scheduler #(
    .VLEN     (VLEN),
    .NUM_REGS (NUM_REGS),
    .NUM_REQ  (NUM_REQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rd_we     (rd_we),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .iss_valid (iss_valid),
    .iss_vd    (iss_vd),
    .iss_ready (iss_ready),
    .chk_addr  (chk_addr),
    .chk_busy  (chk_busy),
    .busy_vec  (busy_vec),
    .wb_err    (wb_err)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [AW+VLEN-1:0] exp_q[$];
  logic               exp_we;
  logic [AW-1:0]      last_addr;
  logic [VLEN-1:0]    last_data;
  logic [AW-1:0]      pay_addr[NUM_REQ];
  logic [VLEN-1:0]    pay_data[NUM_REQ];
  int                 passed;
  int                 total;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] ready;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [VLEN-1:0] act,
                       input logic [VLEN-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [VLEN-1:0] rnd_data();
    logic [VLEN-1:0] d;
    for (int w = 0; w < VLEN / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // Compare the write port against the write captured one cycle earlier.
  task automatic sb_check();
    logic [AW+VLEN-1:0] e;
    check("rd_we", VLEN'(rd_we), VLEN'(exp_we));
    if (exp_we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_addr = e[AW+VLEN-1:VLEN];
      last_data = e[VLEN-1:0];
      check("rd_addr", VLEN'(rd_addr), VLEN'(last_addr));
      check("rd_data", rd_data, last_data);
    end else begin
      check("rd_addr_hold", VLEN'(rd_addr), VLEN'(last_addr));
      check("rd_data_hold", rd_data, last_data);
    end
  endtask

  // driver: one cycle of requests, expected grant given by the caller
  task automatic cyc(input logic [2:0] v, input logic [2:0] rdy);
    @(posedge clk);
    #1;
    iss_valid = 1'b0;
    req_valid = v;
    req_addr  = {pay_addr[2], pay_addr[1], pay_addr[0]};
    req_data  = {pay_data[2], pay_data[1], pay_data[0]};
    @(negedge clk);
    sb_check();
    check("req_ready", VLEN'(req_ready), VLEN'(rdy));
    exp_we = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy[i]) begin
        exp_q.push_back({pay_addr[i], pay_data[i]});
        exp_we      = 1'b1;
        pay_addr[i] = AW'($urandom_range(0, 31));
        pay_data[i] = rnd_data();
      end
    end
  endtask

  task automatic issue(input logic [AW-1:0] vd, input logic exp_rdy);
    iss_valid = 1'b1;
    iss_vd    = vd;
    #1;
    check("iss_ready", VLEN'(iss_ready), VLEN'(exp_rdy));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_we"}, VLEN'(rd_we), '0);
    check({tag, "_rd_addr"}, VLEN'(rd_addr), '0);
    check({tag, "_rd_data"}, rd_data, '0);
    check({tag, "_busy_vec"}, VLEN'(busy_vec), '0);
    check({tag, "_wb_err"}, VLEN'(wb_err), '0);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_vd    = '0;
    chk_addr  = '0;
    exp_we    = 1'b0;
    last_addr = '0;
    last_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pay_addr[i] = AW'(i + 1);
      pay_data[i] = rnd_data();
    end

    tbl[0]  = '{3'b111, 3'b001};
    tbl[1]  = '{3'b111, 3'b010};
    tbl[2]  = '{3'b111, 3'b100};
    tbl[3]  = '{3'b000, 3'b000};
    tbl[4]  = '{3'b100, 3'b100};
    tbl[5]  = '{3'b010, 3'b010};
    tbl[6]  = '{3'b011, 3'b001};
    tbl[7]  = '{3'b110, 3'b010};
    tbl[8]  = '{3'b101, 3'b100};
    tbl[9]  = '{3'b000, 3'b000};
    tbl[10] = '{3'b110, 3'b010};
    tbl[11] = '{3'b001, 3'b001};
    tbl[12] = '{3'b101, 3'b100};
    tbl[13] = '{3'b111, 3'b001};
    tbl[14] = '{3'b000, 3'b000};
    tbl[15] = '{3'b100, 3'b100};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_req_ready", VLEN'(req_ready), '0);
    check("reset_iss_ready", VLEN'(iss_ready), VLEN'(1'b1));
    check("reset_chk_busy", VLEN'(chk_busy), '0);
    rst = 1'b1;

    // arbitration table; first three rows grant ALU, MUL, LSU with vd 1,2,3
    for (int r = 0; r < 16; r++) cyc(tbl[r].valid, tbl[r].ready);
    cyc(3'b000, 3'b000);

    // lone LSU request: granted same cycle, committed next cycle
    pay_addr[REQ_LSU] = AW'(5);
    pay_data[REQ_LSU] = {(VLEN / 8){8'hAB}};
    cyc(3'b100, 3'b100);
    cyc(3'b000, 3'b000);

    // reservation / hazard sequence on v7
    chk_addr = {AW'(0), AW'(0), AW'(7)};
    cyc(3'b000, 3'b000);
    issue(AW'(7), 1'b1);
    cyc(3'b000, 3'b000);
    check("busy_after_issue", VLEN'(busy_vec), VLEN'(SB ? 32'h80 : 32'h0));
    check("chk_busy_v7", VLEN'(chk_busy), VLEN'(SB ? 3'b001 : 3'b000));
    issue(AW'(7), !SB);
    pay_addr[REQ_ALU] = AW'(7);
    cyc(3'b001, 3'b001);
    check("chk_busy_before_commit", VLEN'(chk_busy), VLEN'(SB ? 3'b001 : 3'b000));
    issue(AW'(7), !SB);
    cyc(3'b000, 3'b000);
    check("chk_busy_no_bypass", VLEN'(chk_busy), VLEN'(SB ? 3'b001 : 3'b000));
    issue(AW'(7), 1'b1);
    cyc(3'b000, 3'b000);
    check("busy_same_edge", VLEN'(busy_vec), VLEN'(SB ? 32'h80 : 32'h0));
    check("wb_err_reserved", VLEN'(wb_err), '0);

    // commit to an unreserved register
    pay_addr[REQ_MUL] = AW'(9);
    cyc(3'b010, 3'b010);
    cyc(3'b000, 3'b000);
    check("wb_err_not_yet", VLEN'(wb_err), '0);
    cyc(3'b000, 3'b000);
    check("wb_err_set", VLEN'(wb_err), VLEN'(SB));
    cyc(3'b000, 3'b000);
    check("wb_err_sticky", VLEN'(wb_err), VLEN'(SB));

    // reset in the middle of a burst drops the captured write
    cyc(3'b111, 3'b100);
    cyc(3'b111, 3'b001);
    #2;
    req_valid = '0;
    rst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    exp_we    = 1'b0;
    last_addr = '0;
    last_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(3'b000, 3'b000);
    cyc(3'b000, 3'b000);
    cyc(3'b111, 3'b001);
    cyc(3'b000, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
